demux1to4_buf: RTL and testbench

- Registered 1-to-4 demultiplexer: the write-side counterpart of the team's 4:1 select mux.
- Takes one data word and a 2-bit select (sel[1] = in1 weight, sel[0] = in0 weight), then steers the word into one of four one-entry output buffers (ch0=a, ch1=b, ch2=c, ch3=d).
- Each channel has its own valid/ready handshake. Sits in the ALU result path, feeding per-destination consumers, and serves as the golden conventional reference when checking the adiabatic datapath.

---
 rtl/demux1to4_buf.sv | 140 ++++++++++++++
 tb/tb_demux1to4_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_buf.sv
// demux1to4_buf
// Registered 1-to-4 demultiplexer with a one-entry output buffer per channel.
// A word offered with a select is steered into the buffer of that channel
// (ch0=a, ch1=b, ch2=c, ch3=d). Each channel has its own valid/ready
// handshake and sustains one word per cycle.
//
// Optional build macro: DEMUX_CNT_EN
//   Adds four saturating CNT_W-bit delivery counters, exported on cnt_flat.
//   When the macro is not defined, the cnt_flat port and counters do not exist.
module demux1to4_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_sel,
   input  logic [WIDTH-1:0]   in_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*WIDTH-1:0] out_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [4*CNT_W-1:0] cnt_flat
`endif
);

   // Elaboration-time guard on parameter values.
   generate
      if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
         $error("demux1to4_buf: WIDTH and CNT_W must both be at least 1");
      end
   endgenerate

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state     [4];
   state_t           state_nxt [4];
   logic [WIDTH-1:0] buf_q     [4];
   logic [3:0]       load;
   logic [3:0]       drain;

   // Acceptance depends only on the selected channel's buffer and consumer;
   // it is deliberately independent of in_valid.
   always_comb begin
      in_ready = ~out_valid[in_sel] | out_ready[in_sel];
   end

   // Per-channel load/drain strobes.
   always_comb begin
      load  = '0;
      drain = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         drain[k] = out_valid[k] & out_ready[k];
         load[k]  = in_valid & in_ready & (in_sel == 2'(k));
      end
   end

   // Per-channel next-state: load fills, drain without load empties.
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         state_nxt[k] = state[k];
         unique case (state[k])
            EMPTY: if (load[k])                state_nxt[k] = FULL;
            FULL:  if (drain[k] && !load[k])   state_nxt[k] = EMPTY;
            default:                           state_nxt[k] = EMPTY;
         endcase
      end
   end

   // Channel state registers; reset discards any buffered word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            state[k] <= EMPTY;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            state[k] <= state_nxt[k];
         end
      end
   end

   // Data buffers: capture only on load, otherwise hold (drain does not clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (load[k]) begin
               buf_q[k] <= in_data;
            end
         end
      end
   end

   // Flatten registered channel state onto the output ports.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         out_valid[k]               = (state[k] == FULL);
         out_data[k*WIDTH +: WIDTH] = buf_q[k];
      end
   end

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q [4];

   // Delivery counters: count drains, stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (drain[k] && (cnt_q[k] != '1)) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Export counters, channel k at [k*CNT_W +: CNT_W].
   always_comb begin
      cnt_flat = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf
// Directed bench for demux1to4_buf with hand-computed expectations.
// Define DEMUX_CNT_EN for both files to include the counter checks (CNT_W=2).
module tb_demux1to4_buf;

   localparam int unsigned WIDTH = 8;
`ifdef DEMUX_CNT_EN
   localparam int unsigned CNT_W = 2;
`else
   localparam int unsigned CNT_W = 8;
`endif

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_sel;
   logic [WIDTH-1:0]   in_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_CNT_EN
   logic [4*CNT_W-1:0] cnt_flat;
`endif

   int n_cmp;
   int n_err;

   demux1to4_buf #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX_CNT_EN
      ,
      .cnt_flat  (cnt_flat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] ch(input int k);
      return out_data[k*WIDTH +: WIDTH];
   endfunction

   logic [7:0] words [4];

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
      words[0] = 8'hA0; words[1] = 8'hB1; words[2] = 8'hC2; words[3] = 8'hD3;

      // Reset then idle
      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      tick();
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_data", out_data, 32'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check($sformatf("idle_ready_sel%0d", s), 32'(in_ready), 32'h1);
      end

      // in_valid=0 with toggling select changes nothing
      for (int s = 0; s < 4; s++) begin
         in_sel  = 2'(s);
         in_data = 8'hFF;
         tick();
      end
      check("noval_valid", 32'(out_valid), 32'h0);
      check("noval_data", out_data, 32'h0);

      // Routing sweep
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_sel   = 2'(i);
         in_data  = words[i];
         tick();
         check($sformatf("sweep_valid%0d", i), 32'(out_valid), 32'(4'b0001 << i));
         check($sformatf("sweep_data%0d", i), 32'(ch(i)), 32'(words[i]));
      end
      in_valid = 1'b0;
      tick();
      check("sweep_drained", 32'(out_valid), 32'h0);
      check("sweep_keep_d", 32'(ch(3)), 32'hD3);

      // Backpressure on ch2
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 8'h5A;
      tick();
      check("bp_load_valid", 32'(out_valid), 32'h4);
      check("bp_load_data", 32'(ch(2)), 32'h5A);
      in_data = 8'h77;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("bp_ready%0d", i), 32'(in_ready), 32'h0);
         tick();
         check($sformatf("bp_hold%0d", i), 32'(ch(2)), 32'h5A);
         check($sformatf("bp_hold_v%0d", i), 32'(out_valid[2]), 32'h1);
      end
      in_sel  = 2'd1;
      in_data = 8'h33;
      #1;
      check("bp_other_ready", 32'(in_ready), 32'h1);
      tick();
      check("bp_other_valid", 32'(out_valid), 32'h6);
      check("bp_other_data", 32'(ch(1)), 32'h33);
      check("bp_ch2_still", 32'(ch(2)), 32'h5A);
      in_sel    = 2'd2;
      in_data   = 8'h77;
      out_ready = 4'b1111;
      #1;
      check("bp_drain_ready", 32'(in_ready), 32'h1);
      tick();
      check("bp_nobubble_v", 32'(out_valid), 32'h4);
      check("bp_nobubble_d", 32'(ch(2)), 32'h77);
      check("bp_ch1_keep", 32'(ch(1)), 32'h33);
      in_valid = 1'b0;
      tick();
      check("bp_final_valid", 32'(out_valid), 32'h0);
      check("bp_final_data", 32'(ch(2)), 32'h77);

      // Full throughput on ch3
      out_ready = 4'b1000;
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(8'h10 + i);
         #1;
         check($sformatf("tp_ready%0d", i), 32'(in_ready), 32'h1);
         tick();
         check($sformatf("tp_data%0d", i), 32'(ch(3)), 32'(8'h10 + i));
         check($sformatf("tp_valid%0d", i), 32'(out_valid), 32'h8);
      end
      in_valid = 1'b0;
      tick();
      check("tp_drained", 32'(out_valid), 32'h0);

      // Async reset mid-operation
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 8'hE0;
      tick();
      in_sel  = 2'd1;
      in_data = 8'hE1;
      tick();
      in_valid = 1'b0;
      check("ar_pre_valid", 32'(out_valid), 32'h3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("ar_async_valid", 32'(out_valid), 32'h0);
      check("ar_async_data", out_data, 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("ar_post_valid", 32'(out_valid), 32'h0);
      check("ar_post_data", out_data, 32'h0);

`ifdef DEMUX_CNT_EN
      // Counter saturation: five drains on ch1 with CNT_W=2
      check("cnt_reset", 32'(cnt_flat), 32'h0);
      out_ready = 4'b0010;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'(8'h40 + i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("cnt_ch1_sat", 32'(cnt_flat[1*CNT_W +: CNT_W]), 32'h3);
      check("cnt_all", 32'(cnt_flat), 32'h0C);
      rst_n = 1'b0;
      #1;
      check("cnt_after_rst", 32'(cnt_flat), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
